tpu_host_bridge: RTL

Host-side front end for the TPU accelerator top level. It accepts one valid/ready host request at a time and drives the accelerator's memory-mapped port (`r_w`, `addr`, `dataIn`, `dataOut`). It hides the accelerator's multiply busy window and read capture timing from the host. It returns exactly one response per accepted request.

---
 rtl/tpu_pkg.sv | 37 +++
 rtl/tpu_host_bridge.sv | 114 +++++++++++
 2 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host bridge: address map,
// bridge FSM states and request classification.
package tpu_pkg;

   localparam logic [31:0] A_BASE     = 32'h0000_0100;
   localparam logic [31:0] A_LIMIT    = 32'h0000_013F;
   localparam logic [31:0] B_BASE     = 32'h0000_0200;
   localparam logic [31:0] B_LIMIT    = 32'h0000_023F;
   localparam logic [31:0] C_BASE     = 32'h0000_0300;
   localparam logic [31:0] C_LIMIT    = 32'h0000_037F;
   localparam logic [31:0] START_ADDR = 32'h0000_0400;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_MUL_WAIT,
      S_RSP,
      S_ERR_RSP
   } bridge_state_t;

   typedef struct packed {
      logic mapped;
      logic rd_ok;
   } addr_class_t;

   // Only the C region can be read back; A, B and START are write-only.
   function automatic addr_class_t classify(logic [31:0] a);
      addr_class_t c;
      c.rd_ok  = (a >= C_BASE) && (a <= C_LIMIT);
      c.mapped = ((a >= A_BASE) && (a <= A_LIMIT)) ||
                 ((a >= B_BASE) && (a <= B_LIMIT)) ||
                 c.rd_ok || (a == START_ADDR);
      return c;
   endfunction

endpackage

// File: rtl/tpu_host_bridge.sv
// Host valid/ready front end for the TPU memory-mapped port;
// hides multiply busy time and read capture timing.
module tpu_host_bridge
   import tpu_pkg::*;
#(
   parameter int DIM        = 8,
   parameter int ADDRW      = 16,
   parameter int DATAW      = 64,
   parameter int MUL_CYCLES = 3*DIM-1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_wr,
   input  logic [ADDRW-1:0] req_addr,
   input  logic [DATAW-1:0] req_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_err,
   output logic [DATAW-1:0] rsp_data,
   output logic             tpu_r_w,
   output logic [ADDRW-1:0] tpu_addr,
   output logic [DATAW-1:0] tpu_dataIn,
   input  logic [DATAW-1:0] tpu_dataOut,
   output logic             busy
);

   localparam int CW = $clog2(MUL_CYCLES + 1);

   bridge_state_t    r_state;
   bridge_state_t    w_next;
   logic             r_wr;
   logic [ADDRW-1:0] r_addr;
   logic [DATAW-1:0] r_data;
   logic [DATAW-1:0] r_rsp_data;
   logic [CW-1:0]    r_cnt;

   addr_class_t w_cls;
   logic        w_err;
   logic        w_hs;
   logic        w_start;

   assign w_cls   = classify(32'(req_addr));
   assign w_err   = !w_cls.mapped || (!req_wr && !w_cls.rd_ok);
   assign w_hs    = req_valid && (r_state == S_IDLE);
   assign w_start = r_wr && (32'(r_addr) == START_ADDR);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) w_next = w_err ? S_ERR_RSP : S_ISSUE;
         end
         S_ISSUE: begin
            if (!r_wr)        w_next = S_CAPTURE;
            else if (w_start) w_next = S_MUL_WAIT;
            else              w_next = S_RSP;
         end
         S_CAPTURE:  w_next = S_RSP;
         S_MUL_WAIT: begin
            if (r_cnt == '0) w_next = S_RSP;
         end
         S_RSP, S_ERR_RSP: begin
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Bus is decoded from state alone so reset idles it asynchronously.
   always_comb begin
      req_ready  = (r_state == S_IDLE);
      busy       = (r_state != S_IDLE);
      rsp_valid  = (r_state == S_RSP) || (r_state == S_ERR_RSP);
      rsp_err    = (r_state == S_ERR_RSP);
      rsp_data   = r_rsp_data;
      tpu_r_w    = 1'b0;
      tpu_addr   = '0;
      tpu_dataIn = '0;
      if (r_state == S_ISSUE) begin
         tpu_r_w    = r_wr;
         tpu_addr   = r_addr;
         tpu_dataIn = r_data;
      end else if (r_state == S_CAPTURE) begin
         tpu_addr   = r_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_wr       <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_rsp_data <= '0;
         r_cnt      <= '0;
      end else begin
         r_state <= w_next;
         if (w_hs) begin
            r_wr       <= req_wr;
            r_addr     <= req_addr;
            r_data     <= req_data;
            r_rsp_data <= '0;
         end
         if (r_state == S_CAPTURE) r_rsp_data <= tpu_dataOut;
         if ((r_state == S_ISSUE) && w_start)
            r_cnt <= CW'(MUL_CYCLES - 1);
         else if ((r_state == S_MUL_WAIT) && (r_cnt != '0))
            r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule
